// File: rtl/cpsd_pkg.sv
// Shared helpers for the cross-spectrum datapath blocks.
package cpsd_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/multi_delay_line_if.sv
// Stream/control bundle for multi_delay_line: the producer owns the inputs, the delay line owns the outputs.
interface multi_delay_line_if
    import cpsd_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NB_OF_CHANNELS = 2,
    parameter int MAX_DELAY      = 16
);
    localparam int DELAY_WIDTH = clog2(MAX_DELAY + 1);

    logic                                 en;
    logic                                 clr;
    logic [DELAY_WIDTH-1:0]               delay;
    logic                                 in_valid;
    logic [NB_OF_CHANNELS*DATA_WIDTH-1:0] xin;
    logic                                 out_valid;
    logic [NB_OF_CHANNELS*DATA_WIDTH-1:0] y;
    logic                                 primed;

    modport master (
        output en, clr, delay, in_valid, xin,
        input  out_valid, y, primed
    );

    modport slave (
        input  en, clr, delay, in_valid, xin,
        output out_valid, y, primed
    );
endinterface

// File: rtl/delay_ram.sv
// Sample history storage: synchronous write, combinational read, contents never reset.
module delay_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/multi_delay_line.sv
// Runtime-programmable per-sample delay for packed multi-channel streams; a fill count
// gates out_valid so history from before a reset, flush or delay change is never emitted.
module multi_delay_line
    import cpsd_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NB_OF_CHANNELS = 2,
    parameter int MAX_DELAY      = 16
) (
    input  logic           clk,
    input  logic           rstn,
    multi_delay_line_if.slave bus
);
    localparam int DELAY_WIDTH = clog2(MAX_DELAY + 1);
    localparam int PTR_WIDTH   = (MAX_DELAY > 1) ? clog2(MAX_DELAY) : 1;
    localparam int XW          = DATA_WIDTH * NB_OF_CHANNELS;
    localparam int AW          = DELAY_WIDTH + 1;
    localparam logic [DELAY_WIDTH-1:0] MAX_D   = DELAY_WIDTH'(MAX_DELAY);
    localparam logic [PTR_WIDTH-1:0]   LAST_WP = PTR_WIDTH'(MAX_DELAY - 1);

    logic [PTR_WIDTH-1:0]   r_wp, w_wp_eff, w_wp_nxt, w_rd_idx;
    logic [DELAY_WIDTH-1:0] r_fill, r_delay_q;
    logic [DELAY_WIDTH-1:0] w_delay_sat, w_dq_eff, w_fill_eff, w_fill_flush, w_fill_inc;
    logic [AW-1:0]          w_rd_full;
    logic [XW-1:0]          w_rd_data, r_y;
    logic                   w_delay_chg, w_accept, w_emit;
    logic                   r_out_valid, r_primed;

    assign w_delay_sat  = (bus.delay > MAX_D) ? MAX_D : bus.delay;
    assign w_delay_chg  = (w_delay_sat != r_delay_q);

    // A delay change restarts history this cycle, so a coincident sample is index 0.
    assign w_dq_eff     = w_delay_chg ? w_delay_sat : r_delay_q;
    assign w_fill_eff   = w_delay_chg ? '0 : r_fill;
    assign w_wp_eff     = w_delay_chg ? '0 : r_wp;
    assign w_fill_flush = bus.clr ? '0 : w_fill_eff;

    assign w_accept     = bus.en && bus.in_valid && !bus.clr;
    assign w_emit       = w_accept && (w_fill_eff >= w_dq_eff);
    assign w_fill_inc   = (w_fill_eff == MAX_D) ? w_fill_eff : w_fill_eff + DELAY_WIDTH'(1);
    assign w_wp_nxt     = (w_wp_eff == LAST_WP) ? '0 : w_wp_eff + PTR_WIDTH'(1);

    always_comb begin
        w_rd_full = '0;
        if (AW'(w_wp_eff) >= AW'(w_dq_eff))
            w_rd_full = AW'(w_wp_eff) - AW'(w_dq_eff);
        else
            w_rd_full = AW'(w_wp_eff) + AW'(MAX_DELAY) - AW'(w_dq_eff);
    end
    assign w_rd_idx = w_rd_full[PTR_WIDTH-1:0];

    delay_ram #(
        .WIDTH (XW),
        .DEPTH (MAX_DELAY),
        .AW    (PTR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_wp_eff),
        .i_wdata (bus.xin),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_delay_q   <= '0;
            r_wp        <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_primed    <= 1'b0;
            r_y         <= '0;
        end else begin
            r_primed <= (w_fill_flush >= w_dq_eff);
            if (w_delay_chg) r_delay_q <= w_delay_sat;
            if (bus.clr) begin
                r_fill      <= '0;
                r_wp        <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= w_emit;
                r_fill      <= w_accept ? w_fill_inc : w_fill_eff;
                r_wp        <= w_accept ? w_wp_nxt : w_wp_eff;
                // Zero delay has no stored history to read, so it takes the live sample.
                if (w_emit) r_y <= (w_dq_eff == '0) ? bus.xin : w_rd_data;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
    assign bus.primed    = r_primed;
endmodule

// File: tb/tb_multi_delay_line.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// stream, all compared cycle by cycle against a queue-based model of the sample delay.
module tb_multi_delay_line;
    import cpsd_pkg::*;

    localparam int DW   = 16;
    localparam int NCH  = 2;
    localparam int MAXD = 5;
    localparam int XW   = DW * NCH;
    localparam int DLW  = clog2(MAXD + 1);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    multi_delay_line_if #(.DATA_WIDTH(DW), .NB_OF_CHANNELS(NCH), .MAX_DELAY(MAXD)) bus ();

    multi_delay_line #(.DATA_WIDTH(DW), .NB_OF_CHANNELS(NCH), .MAX_DELAY(MAXD)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int            m_n;
    int            m_dq;
    logic [XW-1:0] m_hist[$];
    logic [XW-1:0] m_y;
    logic          m_ov;
    logic          m_primed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_dq = 0;
        m_hist.delete();
        m_y = '0;
        m_ov = 1'b0;
        m_primed = 1'b0;
    endtask

    // Drive one cycle, advance the model, clock, then compare away from the edge.
    task automatic step(input logic e, input logic c, input int d, input logic v,
                        input logic [XW-1:0] x);
        int sat;
        bus.en = e;
        bus.clr = c;
        bus.delay = DLW'(d);
        bus.in_valid = v;
        bus.xin = x;
        sat = (d > MAXD) ? MAXD : d;
        if (rstn) begin
            if (sat != m_dq) begin
                m_dq = sat;
                m_n = 0;
                m_hist.delete();
            end
            if (c) begin
                m_n = 0;
                m_hist.delete();
            end
            m_primed = (m_n >= m_dq);
            if (!c && e && v) begin
                m_ov = (m_n >= m_dq);
                if (m_ov) m_y = (m_dq == 0) ? x : m_hist[m_hist.size() - m_dq];
                m_hist.push_back(x);
                if (m_hist.size() > MAXD) void'(m_hist.pop_front());
                m_n++;
            end else begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("y", bus.y, m_y);
        chk("primed", 32'(bus.primed), 32'(m_primed));
    endtask

    task automatic pulse_reset();
        #3 rstn = 1'b0;
        #1;
        chk("rst_async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_async_y", bus.y, 32'd0);
        chk("rst_async_primed", 32'(bus.primed), 32'd0);
        model_reset();
        step(1'b1, 1'b0, 3, 1'b1, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 3, 1'b1, 32'hCAFE_F00D);
        #3 rstn = 1'b1;
    endtask

    logic [XW-1:0] xs[32];
    logic [XW-1:0] s_val;
    int            cur_d;

    initial begin
        bus.en = 1'b0;
        bus.clr = 1'b0;
        bus.delay = '0;
        bus.in_valid = 1'b0;
        bus.xin = '0;
        model_reset();
        #3;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_y", bus.y, 32'd0);
        chk("reset_primed", 32'(bus.primed), 32'd0);
        @(posedge clk);
        #4 rstn = 1'b1;

        // delay 3, samples 1,2,3,...: first output after the 4th sample, y = 1,2,...
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 3, 1'b1, {16'(k), 16'(k)});
            chk("d3_ov_lit", 32'(bus.out_valid), 32'(k >= 4));
            chk("d3_y_lit", bus.y, (k >= 4) ? {16'(k - 3), 16'(k - 3)} : 32'd0);
            chk("d3_primed_lit", 32'(bus.primed), 32'(k >= 4));
        end

        // delay 0: registered pass-through, gaps hold y
        step(1'b1, 1'b0, 0, 1'b1, 32'h1234_5678);
        chk("d0_ov_lit", 32'(bus.out_valid), 32'd1);
        chk("d0_y_lit", bus.y, 32'h1234_5678);
        step(1'b1, 1'b0, 0, 1'b0, 32'h1111_1111);
        chk("d0_gap_ov_lit", 32'(bus.out_valid), 32'd0);
        chk("d0_gap_y_lit", bus.y, 32'h1234_5678);
        for (int k = 0; k < 6; k++)
            step(1'b1, 1'b0, 0, 1'($urandom_range(0, 1)), $urandom);

        // delay = MAXD across pointer wrap, then an out-of-range request saturates to the same value
        for (int i = 0; i < 20; i++) begin
            xs[i] = $urandom;
            step(1'b1, 1'b0, MAXD, 1'b1, xs[i]);
            if (i >= MAXD) chk("wrap_y_lit", bus.y, xs[i - MAXD]);
        end
        for (int i = 20; i < 24; i++) begin
            xs[i] = $urandom;
            step(1'b1, 1'b0, 7, 1'b1, xs[i]);
            chk("sat_ov_lit", 32'(bus.out_valid), 32'd1);
            chk("sat_y_lit", bus.y, xs[i - MAXD]);
        end

        // delay 2 stream, then change to 4 with a coincident sample that becomes index 0
        for (int k = 1; k <= 6; k++) step(1'b1, 1'b0, 2, 1'b1, 32'(k * 32'h0001_0001));
        s_val = 32'hAAAA_5555;
        step(1'b1, 1'b0, 4, 1'b1, s_val);
        chk("chg_ov0_lit", 32'(bus.out_valid), 32'd0);
        chk("chg_primed_lit", 32'(bus.primed), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 4, 1'b1, 32'(32'h0B00_0000 + k));
            chk("chg_wait_ov_lit", 32'(bus.out_valid), 32'd0);
        end
        step(1'b1, 1'b0, 4, 1'b1, 32'h0C00_0000);
        chk("chg_resume_ov_lit", 32'(bus.out_valid), 32'd1);
        chk("chg_resume_y_lit", bus.y, s_val);

        // clr coincident with a sample mid-stream
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 3, 1'b1, $urandom);
        step(1'b1, 1'b1, 3, 1'b1, 32'hFFFF_0000);
        chk("clr_ov_lit", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 3, 1'b1, $urandom);

        // enable low for 3 cycles: frozen
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 3, 1'b1, $urandom);
            chk("en0_ov_lit", 32'(bus.out_valid), 32'd0);
        end
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 3, 1'b1, $urandom);

        // async reset mid-stream
        pulse_reset();
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 2, 1'b1, $urandom);

        // randomized traffic
        cur_d = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) cur_d = $urandom_range(0, 7);
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) == 0), cur_d,
                 1'($urandom_range(0, 3) != 0), $urandom);
            if (i == 200) begin
                pulse_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
